// File: rtl/ram_ctrl_pkg.sv
// Shared RAM controller constants and types.
// Used by the RAM port arbiter and its round-robin sub-block.
package ram_ctrl_pkg;

  localparam int RAM_ADDR_WIDTH = 12;
  localparam int RAM_DATA_WIDTH = 64;
  localparam int RAM_NUM_REQ    = 4;

  typedef logic [RAM_ADDR_WIDTH-1:0]      addr_t;
  typedef logic [RAM_DATA_WIDTH-1:0]      data_t;
  typedef logic [$clog2(RAM_NUM_REQ)-1:0] req_id_t;

  function automatic int wrap_inc(int i, int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// gnt_idx is the candidate winner; block masks the grant only.
module rr_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          block,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  // search from the pointer upward, wrapping to 0
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt = (found && !block && !reset)
             ? (N'(1) << gnt_idx) : '0;

  // advance past the winner; hold when nothing is granted
  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (|gnt)
      ptr <= IW'(wrap_inc(int'(gnt_idx), N));
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM write port and one read port among requesters.
// Optional RAM_ARB_COLLISION_FWD_EN forwards write data on collision.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = RAM_NUM_REQ,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ID_WIDTH   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  wr_data,
  output logic [NUM_REQ-1:0]             wr_gnt,
  input  logic [NUM_REQ-1:0]             rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_REQ-1:0]             rd_gnt,
  output logic                           rd_valid,
  output logic [ID_WIDTH-1:0]            rd_id,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           write,
  output logic [ADDR_WIDTH-1:0]          wr_address,
  output logic [DATA_WIDTH-1:0]          data_in,
  output logic                           read,
  output logic [ADDR_WIDTH-1:0]          rd_address,
  input  logic [DATA_WIDTH-1:0]          data_out
);

  logic [ID_WIDTH-1:0]   wr_idx;
  logic [ID_WIDTH-1:0]   rd_idx;
  logic [ID_WIDTH-1:0]   id1;
  logic [ADDR_WIDTH-1:0] wa_sel;
  logic [ADDR_WIDTH-1:0] ra_sel;
  logic [DATA_WIDTH-1:0] wd_sel;
  logic                  collision;
  logic                  rd_block;

  assign wa_sel = wr_addr[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign wd_sel = wr_data[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign ra_sel = rd_addr[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];

  assign collision = (|wr_gnt) && (|rd_req) && (wa_sel == ra_sel);

`ifdef RAM_ARB_COLLISION_FWD_EN
  assign rd_block = 1'b0;
`else
  assign rd_block = collision;
`endif

  rr_arbiter #(.N(NUM_REQ), .IW(ID_WIDTH)) u_wr_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (wr_req),
    .block   (1'b0),
    .gnt     (wr_gnt),
    .gnt_idx (wr_idx)
  );

  rr_arbiter #(.N(NUM_REQ), .IW(ID_WIDTH)) u_rd_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (rd_req),
    .block   (rd_block),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx)
  );

  // register the write winner onto the RAM write port
  always_ff @(posedge clk) begin
    if (reset) begin
      write      <= 1'b0;
      wr_address <= '0;
      data_in    <= '0;
    end else begin
      write <= |wr_gnt;
      if (|wr_gnt) begin
        wr_address <= wa_sel;
        data_in    <= wd_sel;
      end
    end
  end

  // issue the read and carry its owner id through the RAM latency
  always_ff @(posedge clk) begin
    if (reset) begin
      read       <= 1'b0;
      rd_address <= '0;
      id1        <= '0;
      rd_valid   <= 1'b0;
      rd_id      <= '0;
    end else begin
      read     <= |rd_gnt;
      rd_valid <= read;
      rd_id    <= id1;
      if (|rd_gnt) begin
        rd_address <= ra_sel;
        id1        <= rd_idx;
      end
    end
  end

`ifdef RAM_ARB_COLLISION_FWD_EN
  logic                  fwd1;
  logic                  fwd2;
  logic [DATA_WIDTH-1:0] fwd_data;

  // remember colliding reads and return the written data instead
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd1     <= 1'b0;
      fwd2     <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd1     <= collision && (|rd_gnt);
      fwd2     <= fwd1;
      fwd_data <= data_in;
    end
  end

  assign rd_data = fwd2 ? fwd_data : data_out;
`else
  assign rd_data = data_out;
`endif

endmodule
